// File: rtl/flash_cmd_seq.sv
// Request sequencer for the SPI flash byte engine: optional WREN frame, command frame
// (opcode, address, data bytes), then optional 0x05 status polling until WIP clears.
module flash_cmd_seq #(
    parameter int LEN_W    = 9,
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [7:0]       op,
    input  logic             has_addr,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             rd,
    input  logic             wren,
    input  logic             poll,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             spi_start,
    output logic             spi_we,
    output logic [7:0]       spi_wdata,
    output logic             array_done,
    input  logic             spi_done,
    input  logic [7:0]       spi_rdata
);

    localparam int GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);
    localparam int PC_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_OPC, S_ADDR, S_DATA, S_GAP, S_POLL_OPC, S_POLL_RD, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [7:0]        op_q, op_d;
    logic              has_addr_q, has_addr_d;
    logic [23:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rd_q, rd_d;
    logic              poll_q, poll_d;
    logic              main_done_q, main_done_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic              err_q, err_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              byte_st;
    logic              start;
    logic              cur_we;
    logic              cur_ad;
    logic [7:0]        cur_data;
    logic [LEN_W-1:0]  len_m1;
    logic [PC_W-1:0]   poll_nxt;

    assign len_m1   = len_q - LEN_W'(1);
    assign poll_nxt = poll_cnt_q + PC_W'(1);

    assign byte_st = (state_q == S_WREN) || (state_q == S_OPC) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_POLL_OPC) || (state_q == S_POLL_RD);
    // A byte is launched on the first cycle of each byte slot; pend_q marks it outstanding.
    assign start   = byte_st && !pend_q;

    always_comb begin
        cur_we   = 1'b1;
        cur_ad   = 1'b0;
        cur_data = 8'h00;
        case (state_q)
            S_WREN: begin
                cur_data = 8'h06;
                cur_ad   = 1'b1;
            end
            S_OPC: begin
                cur_data = op_q;
                cur_ad   = !has_addr_q && (len_q == '0);
            end
            S_ADDR: begin
                case (idx_q[1:0])
                    2'd0:    cur_data = addr_q[23:16];
                    2'd1:    cur_data = addr_q[15:8];
                    default: cur_data = addr_q[7:0];
                endcase
                cur_ad = (idx_q == LEN_W'(2)) && (len_q == '0);
            end
            S_DATA: begin
                cur_we   = !rd_q;
                cur_data = rd_q ? 8'h00 : wr_data;
                cur_ad   = (idx_q == len_m1);
            end
            S_POLL_OPC: cur_data = 8'h05;
            S_POLL_RD: begin
                cur_we = 1'b0;
                cur_ad = 1'b1;
            end
            default: cur_we = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        op_d        = op_q;
        has_addr_d  = has_addr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rd_d        = rd_q;
        poll_d      = poll_q;
        main_done_d = main_done_q;
        idx_d       = idx_q;
        gap_d       = '0;
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (start) begin
            pend_d  = 1'b1;
            wdata_d = cur_data;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d        = op;
                    has_addr_d  = has_addr;
                    addr_d      = addr;
                    len_d       = len;
                    rd_d        = rd;
                    poll_d      = poll;
                    err_d       = 1'b0;
                    main_done_d = 1'b0;
                    poll_cnt_d  = '0;
                    idx_d       = '0;
                    state_d     = wren ? S_WREN : S_OPC;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    gap_d = '0;
                    if (!main_done_q)  state_d = S_OPC;
                    else if (poll_q)   state_d = S_POLL_OPC;
                    else               state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                if (pend_q && spi_done) begin
                    pend_d = 1'b0;
                    case (state_q)
                        S_WREN: state_d = S_GAP;
                        S_OPC: begin
                            idx_d = '0;
                            if (has_addr_q)          state_d = S_ADDR;
                            else if (len_q != '0)    state_d = S_DATA;
                            else begin
                                main_done_d = 1'b1;
                                state_d     = S_GAP;
                            end
                        end
                        S_ADDR: begin
                            if (idx_q == LEN_W'(2)) begin
                                idx_d = '0;
                                if (len_q != '0) state_d = S_DATA;
                                else begin
                                    main_done_d = 1'b1;
                                    state_d     = S_GAP;
                                end
                            end else begin
                                idx_d = idx_q + LEN_W'(1);
                            end
                        end
                        S_DATA: begin
                            if (rd_q) begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = spi_rdata;
                            end
                            if (idx_q == len_m1) begin
                                main_done_d = 1'b1;
                                state_d     = S_GAP;
                            end else begin
                                idx_d = idx_q + LEN_W'(1);
                            end
                        end
                        S_POLL_OPC: state_d = S_POLL_RD;
                        S_POLL_RD: begin
                            poll_cnt_d = poll_nxt;
                            if (!spi_rdata[0]) begin
                                state_d = S_DONE;
                            end else if (poll_nxt == PC_W'(POLL_MAX)) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_GAP;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            op_q        <= '0;
            has_addr_q  <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
            poll_q      <= 1'b0;
            main_done_q <= 1'b0;
            idx_q       <= '0;
            gap_q       <= '0;
            poll_cnt_q  <= '0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            has_addr_q  <= has_addr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            poll_q      <= poll_d;
            main_done_q <= main_done_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            poll_cnt_q  <= poll_cnt_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // The byte is held from wdata_q while outstanding so wr_data may move on after wr_ack.
    assign spi_start  = start;
    assign spi_we     = byte_st && cur_we;
    assign spi_wdata  = pend_q ? wdata_q : (start ? cur_data : 8'h00);
    assign array_done = start && cur_ad;
    assign wr_ack     = start && (state_q == S_DATA) && !rd_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Directed bench for flash_cmd_seq: a byte-engine model answers spi_start, a negedge
// monitor pops expected bytes, read data and done/err from queues filled by the stimulus.
module tb_flash_cmd_seq;

  localparam int LEN_W    = 9;
  localparam int CS_GAP   = 4;
  localparam int POLL_MAX = 4;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic [7:0]       op;
  logic             has_addr;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             rd;
  logic             wren;
  logic             poll;
  logic [7:0]       wr_data;
  logic             wr_ack;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic             spi_start;
  logic             spi_we;
  logic [7:0]       spi_wdata;
  logic             array_done;
  logic             spi_done;
  logic [7:0]       spi_rdata;

  flash_cmd_seq #(.LEN_W(LEN_W), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .has_addr(has_addr), .addr(addr),
    .len(len), .rd(rd), .wren(wren), .poll(poll), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
    .spi_start(spi_start), .spi_we(spi_we), .spi_wdata(spi_wdata), .array_done(array_done),
    .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];    // {we, array_done, data}
  logic [7:0] rdexp_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] wq[$];
  logic       derr_q[$];

  int cyc = 0;
  int wr_ack_cnt = 0;
  int end_cyc = 0;
  bit have_end = 0;
  bit frame_end = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- byte engine model ----------------
  initial begin
    int cnt;
    logic cur_we;
    cnt = 0;
    cur_we = 1'b1;
    spi_done = 1'b0;
    spi_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_done = 1'b1;
          if (!cur_we && rsp_q.size() > 0) spi_rdata = rsp_q.pop_front();
          else spi_rdata = 8'h00;
        end
      end else if (spi_start) begin
        cnt = 2;
        cur_we = spi_we;
      end
    end
  end

  // write data source: head of wq, advanced after the acked byte is captured
  initial begin
    wr_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    logic [7:0] tmp;
    cyc++;
    if (rst_n) begin
      if (spi_start) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_spi_byte");
        end else begin
          e = exp_q.pop_front();
          check("byte_we_ad", {30'd0, spi_we, array_done}, {30'd0, e[9:8]});
          if (e[9]) check("byte_data", {24'd0, spi_wdata}, {24'd0, e[7:0]});
        end
        if (have_end) begin
          check("cs_gap", {31'd0, (cyc - end_cyc) > CS_GAP}, 32'd1);
          have_end = 0;
        end
        if (array_done) frame_end = 1;
      end
      if (spi_done && frame_end) begin
        end_cyc = cyc;
        have_end = 1;
        frame_end = 0;
      end
      if (wr_ack) begin
        wr_ack_cnt++;
        if (wq.size() > 0) tmp = wq.pop_front();
      end
      if (rd_valid) begin
        if (rdexp_q.size() == 0) fail_now("unexpected_rd_valid");
        else check("rd_data", {24'd0, rd_data}, {24'd0, rdexp_q.pop_front()});
      end
      if (done) begin
        if (derr_q.size() == 0) fail_now("unexpected_done");
        else check("done_err", {31'd0, err}, {31'd0, derr_q.pop_front()});
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        have_end = 0;
        frame_end = 0;
      end
    end else begin
      have_end = 0;
      frame_end = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_b(input logic we, input logic ad, input logic [7:0] d);
    exp_q.push_back({we, ad, d});
  endtask

  task automatic exp_poll(input int n);
    for (int i = 0; i < n; i++) begin
      exp_b(1'b1, 1'b0, 8'h05);
      exp_b(1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic issue(input logic [7:0] o, input logic ha, input logic [23:0] a,
                       input logic [LEN_W-1:0] l, input logic r, input logic w, input logic p);
    @(negedge clk);
    op = o; has_addr = ha; addr = a; len = l; rd = r; wren = w; poll = p;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", {31'd0, busy}, 32'd1);
    check("err_clear_on_req", {31'd0, err}, 32'd0);
  endtask

  task automatic wait_done(input bit spam);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 3000) begin
        fail_now("done_timeout");
        break;
      end
      req = spam && (n % 7 == 3);
      if (req) begin
        op = 8'hC7; addr = 24'hFFFFFF; len = 9'd3; wren = 1'b1;
      end
    end
    req = 1'b0;
    check("bytes_left", exp_q.size(), 32'd0);
    check("rd_left", rdexp_q.size(), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    req = 1'b0; op = 8'h00; has_addr = 1'b0; addr = 24'h0; len = '0;
    rd = 1'b0; wren = 1'b0; poll = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {8'd0, spi_start, spi_we, spi_wdata, array_done, wr_ack, rd_valid, rd_data, busy, done, err},
          32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ID read, with stray req pulses while busy
    exp_b(1, 0, 8'h90); exp_b(1, 0, 8'h00); exp_b(1, 0, 8'h00); exp_b(1, 0, 8'h00);
    exp_b(0, 0, 8'h00); exp_b(0, 1, 8'h00);
    rsp_q.push_back(8'hEF); rsp_q.push_back(8'h17);
    rdexp_q.push_back(8'hEF); rdexp_q.push_back(8'h17);
    derr_q.push_back(1'b0);
    issue(8'h90, 1, 24'h000000, 9'd2, 1, 0, 0);
    wait_done(1);

    // opcode-only request on the cycle right after done
    exp_b(1, 1, 8'h06);
    derr_q.push_back(1'b0);
    issue(8'h06, 0, 24'h0, 9'd0, 0, 0, 0);
    wait_done(0);

    // page program with WREN prefix and 4 polls (WIP=1 three times)
    base = wr_ack_cnt;
    exp_b(1, 1, 8'h06);
    exp_b(1, 0, 8'h02); exp_b(1, 0, 8'h01); exp_b(1, 0, 8'h23); exp_b(1, 0, 8'h45);
    exp_b(1, 0, 8'h11); exp_b(1, 0, 8'h22); exp_b(1, 0, 8'h33); exp_b(1, 1, 8'h44);
    exp_poll(4);
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h00};
    derr_q.push_back(1'b0);
    repeat (2) @(negedge clk);
    issue(8'h02, 1, 24'h012345, 9'd4, 0, 1, 1);
    wait_done(0);
    check("wr_ack_count", wr_ack_cnt - base, 32'd4);

    // poll timeout: WIP stuck at 1
    exp_b(1, 1, 8'hC7);
    exp_poll(POLL_MAX);
    rsp_q = '{8'h01, 8'h01, 8'h01, 8'h01};
    derr_q.push_back(1'b1);
    repeat (2) @(negedge clk);
    issue(8'hC7, 0, 24'h0, 9'd0, 0, 0, 1);
    wait_done(0);
    check("rsp_consumed", rsp_q.size(), 32'd0);
    @(negedge clk);
    check("err_held", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    check("err_held_idle", {31'd0, err}, 32'd1);

    // next request clears err
    exp_b(1, 1, 8'h06);
    derr_q.push_back(1'b0);
    issue(8'h06, 0, 24'h0, 9'd0, 0, 0, 0);
    wait_done(0);

    // async reset during data byte 2 of 4
    base = wr_ack_cnt;
    exp_b(1, 0, 8'h02); exp_b(1, 0, 8'hAB); exp_b(1, 0, 8'hCD); exp_b(1, 0, 8'hEF);
    exp_b(1, 0, 8'hAA); exp_b(1, 0, 8'hBB); exp_b(1, 0, 8'hCC); exp_b(1, 1, 8'hDD);
    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    repeat (2) @(negedge clk);
    issue(8'h02, 1, 24'hABCDEF, 9'd4, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      if (wr_ack_cnt - base >= 2) break;
      @(negedge clk);
    end
    check("reset_point_reached", wr_ack_cnt - base, 32'd2);
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset",
          {8'd0, spi_start, spi_we, spi_wdata, array_done, wr_ack, rd_valid, rd_data, busy, done, err},
          32'd0);
    exp_q.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    // fresh read after reset
    exp_b(1, 0, 8'h03); exp_b(1, 0, 8'h00); exp_b(1, 0, 8'h00); exp_b(1, 0, 8'h10);
    exp_b(0, 1, 8'h00);
    rsp_q = '{8'h5A};
    rdexp_q.push_back(8'h5A);
    derr_q.push_back(1'b0);
    issue(8'h03, 1, 24'h000010, 9'd1, 1, 0, 0);
    wait_done(0);

    repeat (3) @(negedge clk);
    check("done_left", derr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
